// File: rtl/traffic_pkg.sv
// Shared light and fault encodings for the traffic light monitor.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED     = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
    localparam logic [1:0] LIGHT_GREEN   = 2'b10;
    localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

    localparam logic [2:0] FLT_NONE          = 3'd0;
    localparam logic [2:0] FLT_CONFLICT      = 3'd1;
    localparam logic [2:0] FLT_ILLEGAL_CODE  = 3'd2;
    localparam logic [2:0] FLT_ILLEGAL_TRANS = 3'd3;
    localparam logic [2:0] FLT_SHORT_DWELL   = 3'd4;
    localparam logic [2:0] FLT_STUCK         = 3'd5;

    typedef struct packed {
        logic       valid;
        logic [2:0] code;
        logic       road;
    } fault_rec_t;

    function automatic fault_rec_t mk_fault(input logic [2:0] code, input logic road);
        fault_rec_t f;
        f.valid = 1'b1;
        f.code  = code;
        f.road  = road;
        return f;
    endfunction

    // Normal phase order is green -> yellow -> red -> green.
    function automatic logic legal_step(input logic [1:0] from_code, input logic [1:0] to_code);
        return ((from_code == LIGHT_GREEN)  && (to_code == LIGHT_YELLOW)) ||
               ((from_code == LIGHT_YELLOW) && (to_code == LIGHT_RED))    ||
               ((from_code == LIGHT_RED)    && (to_code == LIGHT_GREEN));
    endfunction

endpackage

// File: rtl/light_dwell_tracker.sv
// Per-road previous-code and dwell tracking with per-road violation flags.
// Stuck detection is compiled in only with TRAFFIC_MON_STUCK_CHECK_EN.
module light_dwell_tracker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned MIN_YELLOW = 8,
    parameter int unsigned MAX_DWELL  = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light,
    input  logic       relax,
    output logic       illegal_code,
    output logic       illegal_trans,
    output logic       short_dwell,
    output logic       stuck
);

    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);

    logic [1:0]       prev;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] dwell_nxt;
    logic             changed;

    always_comb begin
        changed = (light != prev);
        if (changed)
            dwell_nxt = CNT_W'(1);
        else if (dwell >= DWELL_MAX)
            dwell_nxt = DWELL_MAX;
        else
            dwell_nxt = dwell + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= LIGHT_RED;
            dwell <= '0;
        end else begin
            prev  <= light;
            dwell <= dwell_nxt;
        end
    end

    assign illegal_code  = (light == LIGHT_ILLEGAL);
    assign illegal_trans = changed && !relax && !legal_step(prev, light);
    assign short_dwell   = changed && !relax &&
                           (((prev == LIGHT_GREEN)  && (dwell < MIN_G)) ||
                            ((prev == LIGHT_YELLOW) && (dwell < MIN_Y)));

`ifdef TRAFFIC_MON_STUCK_CHECK_EN
    // Fires only on the sample where the count first arrives at the ceiling.
    assign stuck = (dwell_nxt == DWELL_MAX) && (changed || (dwell != DWELL_MAX));
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive intersection light-bus checker with a sticky first-fault latch.
// Optional stuck-code check is enabled by defining TRAFFIC_MON_STUCK_CHECK_EN.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned MIN_YELLOW = 8,
    parameter int unsigned MAX_DWELL  = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       emergency,
    input  logic [1:0] lightA,
    input  logic [1:0] lightB,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_road
);

    logic       emergency_d;
    logic       relax;
    logic       a_code, a_trans, a_short, a_stuck;
    logic       b_code, b_trans, b_short, b_stuck;
    fault_rec_t viol_c;
    fault_rec_t viol_q;

    assign relax = emergency || emergency_d;

    light_dwell_tracker #(
        .MIN_GREEN (MIN_GREEN),
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_DWELL (MAX_DWELL),
        .CNT_W     (CNT_W)
    ) u_road_a (
        .clk          (clk),
        .reset        (reset),
        .light        (lightA),
        .relax        (relax),
        .illegal_code (a_code),
        .illegal_trans(a_trans),
        .short_dwell  (a_short),
        .stuck        (a_stuck)
    );

    light_dwell_tracker #(
        .MIN_GREEN (MIN_GREEN),
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_DWELL (MAX_DWELL),
        .CNT_W     (CNT_W)
    ) u_road_b (
        .clk          (clk),
        .reset        (reset),
        .light        (lightB),
        .relax        (relax),
        .illegal_code (b_code),
        .illegal_trans(b_trans),
        .short_dwell  (b_short),
        .stuck        (b_stuck)
    );

    // Priority encode: fault class first, then road A over road B.
    always_comb begin
        viol_c = '0;
        if ((lightA != LIGHT_RED) && (lightB != LIGHT_RED))
            viol_c = mk_fault(FLT_CONFLICT, 1'b0);
        else if (a_code)  viol_c = mk_fault(FLT_ILLEGAL_CODE, 1'b0);
        else if (b_code)  viol_c = mk_fault(FLT_ILLEGAL_CODE, 1'b1);
        else if (a_trans) viol_c = mk_fault(FLT_ILLEGAL_TRANS, 1'b0);
        else if (b_trans) viol_c = mk_fault(FLT_ILLEGAL_TRANS, 1'b1);
        else if (a_short) viol_c = mk_fault(FLT_SHORT_DWELL, 1'b0);
        else if (b_short) viol_c = mk_fault(FLT_SHORT_DWELL, 1'b1);
        else if (a_stuck) viol_c = mk_fault(FLT_STUCK, 1'b0);
        else if (b_stuck) viol_c = mk_fault(FLT_STUCK, 1'b1);
    end

    // Violations are staged one cycle, then latched; a staged violation beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            emergency_d <= 1'b0;
            viol_q      <= '0;
            fault       <= 1'b0;
            fault_code  <= FLT_NONE;
            fault_road  <= 1'b0;
        end else begin
            emergency_d <= emergency;
            viol_q      <= viol_c;
            if (viol_q.valid && (!fault || clear)) begin
                fault      <= 1'b1;
                fault_code <= viol_q.code;
                fault_road <= viol_q.road;
            end else if (clear) begin
                fault      <= 1'b0;
                fault_code <= FLT_NONE;
                fault_road <= 1'b0;
            end
        end
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the intersection light bus. It samples the two 2-bit road light codes every clock and verifies that the codes are legal, the roads never conflict, each road follows the sequence green→yellow→red→green, and each phase respects its minimum and maximum dwell. The first violation is latched as a sticky fault with a code and road identifier, which the top level uses to force all-red and report to software.

## Interface
- MIN_GREEN, 8: minimum consecutive green samples before leaving green.
- MIN_YELLOW, 8: minimum consecutive yellow samples before leaving yellow.
- MAX_DWELL, 64: dwell count at which any code is declared stuck.
- CNT_W, 8: dwell counter width; must satisfy 2^CNT_W > MAX_DWELL.

Ports (clock and reset first):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- emergency  in  1  emergency preemption, as seen by the controller.
- lightA  in  2  road A code: 00 red, 01 yellow, 10 green, 11 illegal.
- lightB  in  2  road B code, same encoding.
- clear  in  1  synchronous clear of the latched fault.
- fault  out  1  sticky fault flag.
- fault_code  out  3  0 none, 1 conflict, 2 illegal code, 3 illegal transition, 4 short dwell, 5 stuck.
- fault_road  out  1  0 = road A, 1 = road B; 0 for a conflict.

## Operation
- Per road, registered state:
  - prev: the previous sampled code.
  - dwell: the count of consecutive samples holding prev.
- Sample update for each road:
  - If the code is unchanged, dwell increments, saturating at MAX_DWELL.
  - If the code changes, dwell becomes 1 and prev takes the new code.
- Checks on each sample, listed in priority order:
  1. Conflict (code 1): both roads are non-red.
  2. Illegal code (code 2): a road reads 11.
  3. Illegal transition (code 3): any change other than G→Y, Y→R or R→G.
  4. Short dwell (code 4): leaving G with dwell < MIN_GREEN, or leaving Y with dwell < MIN_YELLOW.
  5. Stuck (code 5): dwell reaches MAX_DWELL on any code.
- Road A is reported over road B when both roads show the same code of fault.
- Emergency relaxation window: the samples where emergency is high, plus the one sample after it falls (registered emergency_d).
  - Inside the window, G→R, Y→R and R→G are permitted, and checks 3 and 4 are suppressed.
  - Checks 1, 2 and 5 remain active.
- Fault latch:
  - When fault is 0, the highest-priority violation sets fault=1 and loads fault_code and fault_road.
  - When fault is 1, further violations are ignored.
  - When clear is high, fault, fault_code and fault_road go to 0. If a violation is present in the same cycle, the new violation is latched instead, so a new fault wins over clear.
- Dwell tracking continues while a fault is latched.

## Timing
- Reset values:
  - fault=0, fault_code=0, fault_road=0.
  - prev=00 (red) for both roads, dwell=0, emergency_d=0.
- Latency: a violating sample at edge N drives fault, fault_code and fault_road valid after edge N+1. All outputs are registered.
- The first sample after reset is compared against prev=red. This means reset then A green is legal, and reset then A yellow is an illegal transition.
- Asserting reset mid-fault clears everything immediately and asynchronously. Checking restarts from the reset state.
- Stuck is detected on the sample where dwell becomes MAX_DWELL, and is then reported one cycle later.

## Configuration
- TRAFFIC_MON_STUCK_CHECK_EN:
  - Defined: check 5 is compiled in, and fault_code 5 is reachable.
  - Undefined: the stuck compare logic is removed. Dwell still saturates at MAX_DWELL, and fault_code 5 never occurs.

## Structure
- Shared package traffic_pkg holds:
  - light code constants LIGHT_RED=2'b00, LIGHT_YELLOW=2'b01, LIGHT_GREEN=2'b10;
  - fault code constants FLT_NONE through FLT_STUCK.
- Sub-module light_dwell_tracker, instantiated once per road:
  - holds prev and dwell;
  - outputs per-road illegal_code, illegal_trans, short_dwell and stuck flags, taking the relaxation window as an input.
- The top level contains the conflict check, the emergency_d register, priority encoding and the fault latch.

## Test plan
- Nominal loop: 4 cycles of A G11/Y11 with B R, then B G11/Y11 with A R → fault stays 0 throughout.
- Conflict: drive A=10 and B=10 together for 1 sample at edge N → fault=1 at N+1, code=1, road=0.
- Short green: A green for 5 samples, then yellow → code=4, road=0. A subsequent B illegal code does not change the latch.
- Illegal transition: B goes yellow→green → code=3, road=1. Pulse clear with no violation present → all outputs return to 0.
- Emergency: B green at dwell 3, emergency high for 1 cycle, next sample A=10 and B=00 → no fault. Then B goes R→Y with emergency low → code=3.
- Stuck (macro defined): A green held for 64 samples → code=5 one cycle after the 64th sample. With the macro undefined, the same stimulus gives no fault. Assert reset mid-fault → outputs go to 0 immediately.
